// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Serial-to-parallel UART receiver. Each frame is 1 start bit (0),
//   DATA_BITS data bits sent MSB first, and 1 stop bit (1). The first data
//   bit received lands in rx_data[DATA_BITS-1].
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit (>= 4, even)
//   DATA_BITS    : data bits per frame (>= 2)
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst_n     in   synchronous active-low reset
//   rx        in   asynchronous serial line, idles high
//   rx_data   out  last good received word, held until the next good frame
//   rx_valid  out  1-cycle pulse when rx_data updates
//   frame_err out  1-cycle pulse when the stop bit samples low
//   busy      out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Registers
    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [CW-1:0]          r_clk_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;

    // Next-state values
    state_t                 w_state_nxt;
    logic [CW-1:0]          w_clk_nxt;
    logic [BW-1:0]          w_bit_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic [DATA_BITS-1:0]   w_data_nxt;
    logic                   w_valid_nxt;
    logic                   w_ferr_nxt;
    logic                   w_rx_s;

    // Synchronised line; every decision below uses this, never raw rx.
    assign w_rx_s = r_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_clk_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_data   <= w_data_nxt;
            r_rx_valid  <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_rx_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end

            // Re-check the line half a bit in; a high level means a glitch.
            S_START: begin
                if (r_clk_cnt == CLK_HALF) begin
                    w_clk_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_clk_nxt = r_clk_cnt + CW'(1);
                end
            end

            // Counter was aligned to mid start bit, so each full period
            // lands on the middle of the next data bit.
            S_DATA: begin
                if (r_clk_cnt == CLK_LAST) begin
                    w_clk_nxt   = '0;
                    w_shift_nxt = {r_shift[DATA_BITS-2:0], w_rx_s};
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + BW'(1);
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + CW'(1);
                end
            end

            // Decide at mid stop bit; returning to IDLE here lets the next
            // start edge be caught half a bit early.
            S_STOP: begin
                if (r_clk_cnt == CLK_LAST) begin
                    w_clk_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + CW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_clk_nxt   = '0;
            end
        endcase
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Scoreboard bench for uart_rx (CLKS_PER_BIT=16, DATA_BITS=8). Frames are
//   driven bit-accurately; each frame's expected outcome is queued when it
//   starts and a monitor pops it when the receiver strobes an output.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int LAT = CPB * (DB + 1) + CPB / 2 + 2;

    logic          clk;
    logic          rst_n;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct {
        bit            is_err;
        logic [DB-1:0] data;
        int            start_cyc;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            valid_cyc_prev = 0;
    int            valid_cyc_last = 0;
    bit            busy_seen = 0;
    logic [DB-1:0] model_last = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per output strobe.
    always @(negedge clk) begin
        if (busy) busy_seen = 1;
        if (rst_n && (rx_valid || frame_err)) begin
            if (rx_valid && frame_err) begin
                check("valid_and_err_together", 1, 0);
            end else if (sb_q.size() == 0) begin
                check("unexpected_output", {30'd0, rx_valid, frame_err}, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("strobe_kind", {30'd0, rx_valid, frame_err}, e.is_err ? 1 : 2);
                check("rx_data", int'(rx_data), int'(e.data));
                if (rx_valid) begin
                    int lat;
                    lat = cyc - e.start_cyc;
                    n_cmp++;
                    if (lat < LAT - 1 || lat > LAT + 1) begin
                        n_bad++;
                        $display("FAIL latency: got %0d expected %0d+/-1", lat, LAT);
                    end
                    valid_cyc_prev = valid_cyc_last;
                    valid_cyc_last = cyc;
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 rx = b;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 rx = 1'b1;
        end
    endtask

    // Reference model: a good stop delivers the word; a bad stop flags an
    // error and leaves the previously delivered word in place.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        exp_t e;
        @(posedge clk);
        #1 rx = 1'b0;
        e.start_cyc = cyc;
        e.is_err    = !stop;
        if (stop) model_last = d;
        e.data = model_last;
        sb_q.push_back(e);
        repeat (CPB - 1) @(posedge clk);
        for (int i = DB - 1; i >= 0; i--) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    initial begin
        logic [DB-1:0] d81;
        rst_n = 1'b0;
        rx    = 1'b1;

        // T1: reset with rx toggling
        repeat (3) begin
            @(posedge clk);
            #1 rx = ~rx;
        end
        @(negedge clk);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        rx = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(10);
        @(negedge clk);
        check("post_reset_busy", int'(busy), 0);

        // T2: single frame 0xA5
        send_frame(8'hA5, 1'b1);
        idle(4);
        @(negedge clk);
        check("t2_busy_low", int'(busy), 0);
        check("t2_drained", sb_q.size(), 0);

        // T3: back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(4);
        check("t3_valid_spacing", valid_cyc_last - valid_cyc_prev, CPB * (DB + 2));

        // T4: 4-clk glitch
        idle(10);
        busy_seen = 0;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        idle(30);
        @(negedge clk);
        check("t4_busy_pulsed", int'(busy_seen), 1);
        check("t4_busy_idle", int'(busy), 0);

        // T5: bad stop bit on 0x3C
        send_frame(8'h3C, 1'b0);
        idle(24);
        @(negedge clk);
        check("t5_rx_data_held", int'(rx_data), 8'hFF);
        check("t5_drained", sb_q.size(), 0);

        // T6: reset during data bit 4 of 0x81, then 0x42
        d81 = 8'h81;
        drive_bit(1'b0);
        for (int i = DB - 1; i >= DB - 4; i--) drive_bit(d81[i]);
        @(posedge clk);
        #1 rx = d81[DB-5];
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 begin
            rx    = 1'b1;
            rst_n = 1'b1;
        end
        model_last = '0;
        idle(20);
        @(negedge clk);
        check("t6_rx_data_cleared", int'(rx_data), 0);
        check("t6_busy", int'(busy), 0);
        send_frame(8'h42, 1'b1);
        idle(4);
        @(negedge clk);
        check("t6_rx_data", int'(rx_data), 8'h42);

        // Randomised frames with random gaps and occasional bad stop bits
        repeat (24) begin
            logic [DB-1:0] d;
            logic          stp;
            d   = DB'($urandom_range(0, 255));
            stp = ($urandom_range(0, 4) != 0);
            send_frame(d, stp);
            idle(stp ? int'($urandom_range(0, 12)) : 20 + int'($urandom_range(0, 10)));
        end

        // Drain, bounded
        for (int k = 0; k < 400 && sb_q.size() != 0; k++) @(posedge clk);
        idle(20);
        check("final_queue_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
